// File: rtl/register_file_sb.sv
// Parametrised register file with write-to-read bypass, optional zero
// register and a per-register busy scoreboard for issue/writeback tracking.
module register_file_sb #(
  parameter int DWIDTH   = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WEN,
  input  logic [AW-1:0]           wsel,
  input  logic [DWIDTH-1:0]       wdat,
  input  logic                    res_en,
  input  logic [AW-1:0]           res_sel,
  input  logic                    flush,
  input  logic [NREAD*AW-1:0]     rsel,
  output logic [NREAD*DWIDTH-1:0] rdat,
  output logic [NREAD-1:0]        rbusy,
  output logic [AW:0]             busy_cnt
);

  localparam int  CW = AW + 1;
  localparam bit  ZR = (ZERO_REG != 0);

  if (NREGS < 2 || (1 << AW) != NREGS) begin : g_bad_nregs
    $error("register_file_sb: NREGS must be a power of two >= 2");
  end
  if (NREAD < 1) begin : g_bad_nread
    $error("register_file_sb: NREAD must be >= 1");
  end

  logic [DWIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              wr_ok;
  logic              rs_ok;
  logic              inc;
  logic              dec;

  assign wr_ok = WEN && !(ZR && wsel == '0);
  assign rs_ok = res_en && !(ZR && res_sel == '0);

  // A same-cycle reserve wins over the release: it is a newer producer.
  assign inc = rs_ok && !busy[res_sel];
  assign dec = wr_ok && busy[wsel]
             && !(rs_ok && res_sel == wsel);

  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[wsel] = 1'b0;
    if (rs_ok) busy_nxt[res_sel] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = busy_cnt;
    if (inc) cnt_nxt = cnt_nxt + CW'(1);
    if (dec) cnt_nxt = cnt_nxt - CW'(1);
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[wsel] <= wdat;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]     s;
    logic [DWIDTH-1:0] d;
    logic              b;

    assign s = rsel[i*AW +: AW];

    always_comb begin
      d = regs[s];
      b = busy[s];
      if (ZR && s == '0) begin
        d = '0;
        b = 1'b0;
      end else if (WEN && wsel == s) begin
        d = wdat;
        b = 1'b0;
      end
    end

    assign rdat[i*DWIDTH +: DWIDTH] = d;
    assign rbusy[i]                 = b;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: default, no-zero-register and
// wide/four-port configurations driven side by side.
module tb_register_file_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic        res_en;
  logic [4:0]  res_sel;
  logic        flush;
  logic [9:0]  rsel;
  logic [63:0] rdat;
  logic [1:0]  rbusy;
  logic [5:0]  busy_cnt;
  logic [63:0] n_rdat;
  logic [1:0]  n_rbusy;
  logic [5:0]  n_cnt;

  logic         w_wen;
  logic [3:0]   w_wsel;
  logic [63:0]  w_wdat;
  logic         w_res_en;
  logic [3:0]   w_res_sel;
  logic         w_flush;
  logic [15:0]  w_rsel;
  logic [255:0] w_rdat;
  logic [3:0]   w_rbusy;
  logic [4:0]   w_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  register_file_sb dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .res_en(res_en), .res_sel(res_sel), .flush(flush),
    .rsel(rsel), .rdat(rdat), .rbusy(rbusy), .busy_cnt(busy_cnt)
  );

  register_file_sb #(.ZERO_REG(0)) dut_nz (
    .CLK(CLK), .RST(RST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .res_en(res_en), .res_sel(res_sel), .flush(flush),
    .rsel(rsel), .rdat(n_rdat), .rbusy(n_rbusy), .busy_cnt(n_cnt)
  );

  register_file_sb #(.DWIDTH(64), .NREGS(16), .NREAD(4)) dut_w (
    .CLK(CLK), .RST(RST), .WEN(w_wen), .wsel(w_wsel), .wdat(w_wdat),
    .res_en(w_res_en), .res_sel(w_res_sel), .flush(w_flush),
    .rsel(w_rsel), .rdat(w_rdat), .rbusy(w_rbusy), .busy_cnt(w_cnt)
  );

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        res_en;
    logic [4:0]  res_sel;
    logic        flush;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [5:0]  ec;
    logic [31:0] n0;
    logic [5:0]  nc;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [63:0] wv(int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  initial begin
    // rst wen wsel wdat res_en res_sel flush r0 r1 | e0 e1 eb ec n0 nc
    tbl[0]  = '{0,1,5,32'hDEADBEEF,0,0,0,5,0, 32'hDEADBEEF,0,2'b00,0, 32'hDEADBEEF,0};
    tbl[1]  = '{1,0,0,0,1,5,0,5,0, 32'hDEADBEEF,0,2'b00,0, 32'hDEADBEEF,0};
    tbl[2]  = '{0,0,0,0,0,0,0,5,7, 0,0,2'b00,0, 0,0};
    tbl[3]  = '{0,1,7,32'h12345678,0,0,0,7,0, 32'h12345678,0,2'b00,0, 32'h12345678,0};
    tbl[4]  = '{0,0,0,0,0,0,0,7,0, 32'h12345678,0,2'b00,0, 32'h12345678,0};
    tbl[5]  = '{0,1,0,32'hFFFFFFFF,0,0,0,0,7, 0,32'h12345678,2'b00,0, 32'hFFFFFFFF,0};
    tbl[6]  = '{0,0,0,0,1,0,0,0,0, 0,0,2'b00,0, 32'hFFFFFFFF,0};
    tbl[7]  = '{0,0,0,0,0,0,0,0,0, 0,0,2'b00,0, 32'hFFFFFFFF,1};
    tbl[8]  = '{0,0,0,0,1,3,0,3,9, 0,0,2'b00,0, 0,1};
    tbl[9]  = '{0,0,0,0,1,9,0,3,9, 0,0,2'b01,1, 0,2};
    tbl[10] = '{0,1,3,32'hA5,0,0,0,3,9, 32'hA5,0,2'b10,2, 32'hA5,3};
    tbl[11] = '{0,0,0,0,0,0,0,3,9, 32'hA5,0,2'b10,1, 32'hA5,2};
    tbl[12] = '{0,1,9,32'h99,1,9,0,9,3, 32'h99,32'hA5,2'b00,1, 32'h99,2};
    tbl[13] = '{0,0,0,0,0,0,0,9,3, 32'h99,32'hA5,2'b01,1, 32'h99,2};
    tbl[14] = '{0,0,0,0,1,1,0,1,0, 0,0,2'b00,1, 0,2};
    tbl[15] = '{0,0,0,0,1,2,0,1,0, 0,0,2'b01,2, 0,3};
    tbl[16] = '{0,0,0,0,1,4,0,1,0, 0,0,2'b01,3, 0,4};
    tbl[17] = '{0,1,2,32'h55,1,6,1,2,4, 32'h55,0,2'b10,4, 32'h55,5};
    tbl[18] = '{0,0,0,0,0,0,0,2,6, 32'h55,0,2'b00,0, 32'h55,0};

    RST = 1'b1; WEN = 1'b0; wsel = '0; wdat = '0;
    res_en = 1'b0; res_sel = '0; flush = 1'b0; rsel = '0;
    w_wen = 1'b0; w_wsel = '0; w_wdat = '0; w_res_en = 1'b0;
    w_res_sel = '0; w_flush = 1'b0; w_rsel = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("reset_cnt", -1, 64'(busy_cnt), 0);
    chk("reset_wcnt", -1, 64'(w_cnt), 0);
    @(posedge CLK); #1;

    for (int i = 0; i < 19; i++) begin
      RST = tbl[i].rst; WEN = tbl[i].wen;
      wsel = tbl[i].wsel; wdat = tbl[i].wdat;
      res_en = tbl[i].res_en; res_sel = tbl[i].res_sel;
      flush = tbl[i].flush; rsel = {tbl[i].r1, tbl[i].r0};
      #1;
      chk("rdat0", i, 64'(rdat[31:0]), 64'(tbl[i].e0));
      chk("rdat1", i, 64'(rdat[63:32]), 64'(tbl[i].e1));
      chk("rbusy", i, 64'(rbusy), 64'(tbl[i].eb));
      chk("busy_cnt", i, 64'(busy_cnt), 64'(tbl[i].ec));
      chk("nz_rdat0", i, 64'(n_rdat[31:0]), 64'(tbl[i].n0));
      chk("nz_cnt", i, 64'(n_cnt), 64'(tbl[i].nc));
      @(posedge CLK); #1;
    end
    RST = 1'b0; WEN = 1'b0; res_en = 1'b0; flush = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      w_wen = 1'b1; w_wsel = 4'(i); w_wdat = wv(i);
      @(posedge CLK); #1;
    end
    w_wen = 1'b1; w_wsel = 4'd3; w_wdat = 64'hFEED_FACE_CAFE_BEEF;
    w_rsel = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    chk("w_port0", 0, w_rdat[63:0], wv(1));
    chk("w_port1", 1, w_rdat[127:64], wv(2));
    chk("w_port2_byp", 2, w_rdat[191:128], 64'hFEED_FACE_CAFE_BEEF);
    chk("w_port3", 3, w_rdat[255:192], wv(4));
    chk("w_rbusy", 4, 64'(w_rbusy), 0);
    @(posedge CLK); #1;
    w_wen = 1'b0; w_res_en = 1'b1; w_res_sel = 4'd4;
    #1;
    chk("w_port2_held", 5, w_rdat[191:128], 64'hFEED_FACE_CAFE_BEEF);
    chk("w_rbusy_same", 6, 64'(w_rbusy), 0);
    @(posedge CLK); #1;
    w_res_en = 1'b0;
    #1;
    chk("w_rbusy_res", 7, 64'(w_rbusy), 64'b1000);
    chk("w_cnt", 8, 64'(w_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
